dmem_line_server: RTL and testbench
===================================

# dmem_line_server

Backing data-memory responder that sits on the memory side of the data cache's refill/write port. It accepts one request at a time over a valid/ready channel, applies 32-bit word writes, and returns the whole aligned 128-bit line after a fixed, parameterised latency over a second valid/ready channel. It is the simulation/FPGA memory model the cache talks to; it never initiates traffic.

## Interface
- MEM_WORDS, 4096: memory depth in 32-bit words; power of two, ≥4.
- LATENCY, 4: cycles from request acceptance to first `rsp_valid_o`; ≥1.
- INIT_FILE, "": hex image loaded with `$readmemh` at time zero if non-empty.

- clk_i  in  1  clock; all logic on rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request this cycle.
- addr_i  in  32  byte address of request.
- we_i  in  1  1 = word write, 0 = line read.
- data_wr_i  in  32  write data (used when `we_i`=1).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester consumes response this cycle.
- rsp_mem_addr_o  out  32  line-aligned address of the response.
- data_line_o  out  128  line contents; word 0 in [31:0], word 3 in [127:96].

## Operation
- Word index `widx = addr_i[IW+1:2]`, `IW = $clog2(MEM_WORDS)`; bits above IW+1 ignored (address aliases modulo memory size). Line index = `widx[IW-1:2]`. `addr_i[1:0]` ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready_o`=1. On `req_valid_i`: latch `{addr_i[31:4],4'b0}` into response address, latch line index; if `we_i`, write `data_wr_i` to `widx` in the same edge; load counter with LATENCY-1; go to WAIT (or straight to RESP if LATENCY=1).
  - WAIT: `req_ready_o`=0; decrement counter; when counter reaches 0 go to RESP, capturing the line from the array on that edge.
  - RESP: `rsp_valid_o`=1, address/line held stable; on `rsp_ready_i` go to IDLE.
- Every accepted request, read or write, produces exactly one response. For writes the returned line already contains the new word.
- Single outstanding request; no request is accepted in WAIT or RESP, including the cycle `rsp_ready_i` completes a response (back-to-back requests spaced by ≥1 IDLE cycle).
- Counter width `$clog2(LATENCY+1)`; no wrap: it is only loaded in IDLE and stops at 0.
- Memory contents are not affected by reset.

## Timing
- Reset (rstn_i=0 at an edge): state←IDLE, counter←0, `rsp_valid_o`=0, `rsp_mem_addr_o`=0, `data_line_o`=0. `req_ready_o` forced 0 while `rstn_i`=0, 1 from the first cycle after.
- Reset mid-operation: pending response discarded, no response emitted; a write accepted before reset remains in memory.
- Request accepted at edge T → `rsp_valid_o` high from edge T+LATENCY until the edge where `rsp_ready_i`=1 (inclusive).
- `req_ready_o` is a function of state only (no combinational path from `req_valid_i`); `rsp_valid_o`, `rsp_mem_addr_o`, `data_line_o` are registered.
- Requester must hold `addr_i`/`we_i`/`data_wr_i` only during the accepting cycle; later changes are ignored.
- Response data reflects array state at the WAIT→RESP edge; since no other access can occur, equals state after the request's own write.

## Test plan
- Reset, then read addr 0x0000_0010 with INIT_FILE words 4..7 = 0x11,0x22,0x33,0x44 → after 4 cycles `rsp_valid_o`=1, `rsp_mem_addr_o`=0x10, `data_line_o`=0x00000044_00000033_00000022_00000011.
- Write 0xDEADBEEF to 0x0000_0028, `rsp_ready_i`=1 → response at T+4 with `rsp_mem_addr_o`=0x20 and bits [95:64]=0xDEADBEEF; subsequent read of 0x24 returns same line.
- Hold `rsp_ready_i`=0 for 10 cycles after response → `rsp_valid_o`, address, line stable; `req_ready_o`=0 throughout; `req_valid_i` pulses ignored.
- Aliasing: MEM_WORDS=4096, write 0x5 to 0x0000_4000 → read of 0x0000_0000 returns 0x5 in [31:0].
- LATENCY=1 build: request at T → `rsp_valid_o` at T+1; back-to-back requests accepted every 3 cycles.
- Assert `rstn_i`=0 in WAIT after a write of 0x7 to 0x30 → no response ever appears, `req_ready_o`=1 after release, read of 0x30 returns 0x7.

Source files
------------

// File: rtl/dmem_line_server.sv
// Line-granular backing memory for the data cache refill/write port.
// One request at a time; every request returns its aligned 128-bit line after LATENCY cycles.
module dmem_line_server #(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4,
    parameter     INIT_FILE = ""
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [31:0]  addr_i,
    input  logic         we_i,
    input  logic [31:0]  data_wr_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [31:0]  rsp_mem_addr_o,
    output logic [127:0] data_line_o
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0]   mem [MEM_WORDS];
    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] widx;
    logic [IW-1:0] line_base;
    logic          accept;
    logic          unused_addr_lsb;

    // Upper address bits alias modulo the memory size; byte offset is ignored.
    assign widx            = addr_i[IW+1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    assign req_ready_o = rstn_i && (state == IDLE);
    assign accept      = req_ready_o && req_valid_i;

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i)
            mem[widx] <= data_wr_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            cnt            <= '0;
            rsp_valid_o    <= 1'b0;
            rsp_mem_addr_o <= '0;
            data_line_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        rsp_mem_addr_o <= {addr_i[31:4], 4'b0000};
                        line_base      <= widx & ~IW'(3);
                        cnt            <= CW'(LATENCY - 1);
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // Capture happens after the request's own write has landed.
                    if (cnt == '0) begin
                        data_line_o <= {mem[line_base | IW'(3)], mem[line_base | IW'(2)],
                                        mem[line_base | IW'(1)], mem[line_base]};
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_line_server.sv
// Directed bench for dmem_line_server: LATENCY=4 instance for function, LATENCY=1 instance for pacing.
module tb_dmem_line_server;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic         a_valid = 1'b0, a_we = 1'b0, a_rsp_ready = 1'b0;
    logic [31:0]  a_addr = '0, a_wdata = '0;
    logic         a_req_ready, a_rsp_valid;
    logic [31:0]  a_rsp_addr;
    logic [127:0] a_line;

    logic         b_valid = 1'b0, b_we = 1'b0, b_rsp_ready = 1'b0;
    logic [31:0]  b_addr = '0, b_wdata = '0;
    logic         b_req_ready, b_rsp_valid;
    logic [31:0]  b_rsp_addr;
    logic [127:0] b_line;

    dmem_line_server #(.MEM_WORDS(4096), .LATENCY(4), .INIT_FILE("")) dut_a (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(a_valid), .req_ready_o(a_req_ready),
        .addr_i(a_addr), .we_i(a_we), .data_wr_i(a_wdata), .rsp_valid_o(a_rsp_valid),
        .rsp_ready_i(a_rsp_ready), .rsp_mem_addr_o(a_rsp_addr), .data_line_o(a_line)
    );

    dmem_line_server #(.MEM_WORDS(4096), .LATENCY(1), .INIT_FILE("")) dut_b (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(b_valid), .req_ready_o(b_req_ready),
        .addr_i(b_addr), .we_i(b_we), .data_wr_i(b_wdata), .rsp_valid_o(b_rsp_valid),
        .rsp_ready_i(b_rsp_ready), .rsp_mem_addr_o(b_rsp_addr), .data_line_o(b_line)
    );

    localparam logic [127:0] ALL = {128{1'b1}};
    localparam logic [127:0] W0  = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
    localparam logic [127:0] W2  = 128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on dut_a at #1 after an edge, then scramble inputs and wait for the response.
    task automatic send_a(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wd, input logic early_ready);
        int n;
        chk({tag, "_req_ready"}, 128'(a_req_ready), 128'(1));
        a_valid = 1'b1; a_addr = addr; a_we = we; a_wdata = wd;
        @(posedge clk); #1;
        a_valid = 1'b0; a_addr = 32'hFFFF_FFF0; a_we = 1'b0; a_wdata = 32'h0BAD_F00D;
        a_rsp_ready = early_ready;
        n = 0;
        while (a_rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(4));
    endtask

    task automatic consume_a(input string tag);
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, 128'(a_rsp_valid), 128'(0));
    endtask

    task automatic do_a(input string tag, input logic [31:0] addr, input logic we,
                        input logic [31:0] wd, input logic [31:0] exp_addr,
                        input logic [127:0] exp_line, input logic [127:0] mask);
        send_a(tag, addr, we, wd, 1'b0);
        chk({tag, "_rsp_addr"}, 128'(a_rsp_addr), 128'(exp_addr));
        chk({tag, "_line"}, a_line & mask, exp_line & mask);
        consume_a(tag);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'(a_req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(a_rsp_valid), 128'(0));
        chk("rst_rsp_addr", 128'(a_rsp_addr), 128'(0));
        chk("rst_line", a_line, 128'(0));
        rstn = 1'b1;
        #1;
        chk("post_rst_req_ready", 128'(a_req_ready), 128'(1));

        // Populate words 4..7, then read the line back
        do_a("w4", 32'h0000_0010, 1'b1, 32'h11, 32'h10, '0, '0);
        do_a("w5", 32'h0000_0014, 1'b1, 32'h22, 32'h10, '0, '0);
        do_a("w6", 32'h0000_0018, 1'b1, 32'h33, 32'h10, '0, '0);
        do_a("w7", 32'h0000_001F, 1'b1, 32'h44, 32'h10,
             128'h00000044_00000033_00000022_00000011, ALL);
        do_a("rd10", 32'h0000_0010, 1'b0, 32'h0, 32'h10,
             128'h00000044_00000033_00000022_00000011, ALL);

        // Line 0x20: fill, then write 0xDEADBEEF to 0x28 with rsp_ready already high
        do_a("w8", 32'h0000_0020, 1'b1, 32'hA0, 32'h20, '0, '0);
        do_a("w9", 32'h0000_0024, 1'b1, 32'hA1, 32'h20, '0, '0);
        do_a("w11", 32'h0000_002C, 1'b1, 32'hA3, 32'h20, '0, '0);
        send_a("wbeef", 32'h0000_0028, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("wbeef_rsp_addr", 128'(a_rsp_addr), 128'(32'h20));
        chk("wbeef_word2", a_line & W2, 128'hDEADBEEF_0000_0000_0000_0000 & W2);
        consume_a("wbeef");
        do_a("rd24", 32'h0000_0024, 1'b0, 32'h0, 32'h20,
             128'h000000A3_DEADBEEF_000000A1_000000A0, ALL);

        // Stall: response held, new requests ignored for 10 cycles
        send_a("stall", 32'h0000_0024, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0020; a_wdata = 32'h0000_0BAD;
            @(posedge clk); #1;
            chk("stall_rsp_valid", 128'(a_rsp_valid), 128'(1));
            chk("stall_rsp_addr", 128'(a_rsp_addr), 128'(32'h20));
            chk("stall_line", a_line, 128'h000000A3_DEADBEEF_000000A1_000000A0);
            chk("stall_req_ready", 128'(a_req_ready), 128'(0));
        end
        a_valid = 1'b0; a_we = 1'b0;
        consume_a("stall");
        do_a("rd20_after_stall", 32'h0000_0020, 1'b0, 32'h0, 32'h20,
             128'h000000A3_DEADBEEF_000000A1_000000A0, ALL);

        // Aliasing: 0x4000 maps onto word 0 of a 4096-word array
        do_a("w4000", 32'h0000_4000, 1'b1, 32'h5, 32'h4000, 128'h5, W0);
        do_a("rd0_alias", 32'h0000_0000, 1'b0, 32'h0, 32'h0, 128'h5, W0);

        // Reset while waiting: no response, write survives
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0030; a_wdata = 32'h7;
        @(posedge clk); #1;
        a_valid = 1'b0; a_we = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst_wait_req_ready_low", 128'(a_req_ready), 128'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        chk("rst_wait_req_ready_high", 128'(a_req_ready), 128'(1));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rst_wait_no_rsp", 128'(a_rsp_valid), 128'(0));
        end
        do_a("rd30", 32'h0000_0030, 1'b0, 32'h0, 32'h30, 128'h7, W0);

        // LATENCY=1: request and response ready held high -> one accept every 3 cycles
        b_valid = 1'b1; b_addr = 32'h0000_0044; b_we = 1'b0; b_rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("l1_req_ready", 128'(b_req_ready), 128'((i % 3) == 0));
            chk("l1_rsp_valid", 128'(b_rsp_valid), 128'((i % 3) == 2));
            if ((i % 3) == 2)
                chk("l1_rsp_addr", 128'(b_rsp_addr), 128'(32'h40));
        end
        @(negedge clk);
        b_valid = 1'b0; b_rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk("l1_idle_ready", 128'(b_req_ready), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
